gpio_input_port: RTL and testbench
==================================

GPIO_INPUT_PORT -- requirements
Module: gpio_input_port

Interface
REQ-001 SHALL have parameter N_SW, default 8: number of switch inputs from the GPIO expansion board.
REQ-002 SHALL have parameter N_BTN, default 4: number of pushbutton inputs from the GPIO expansion board.
REQ-003 SHALL have parameter DB_COUNT, default 50000: debounce stability interval in clock cycles, legal range 1..65535.
REQ-004 SHALL have port clock, input, 1: system clock; all flops rising-edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port sw_raw, input, N_SW: raw switch levels, asynchronous to clock.
REQ-007 SHALL have port btn_raw, input, N_BTN: raw button levels, 1 = pressed, asynchronous to clock.
REQ-008 SHALL have port rd_en, input, 1: read request from the computer, one read per high cycle.
REQ-009 SHALL have port rd_addr, input, 2: register select, sampled with rd_en.
REQ-010 SHALL have port rd_data, output, 16: read data, zero-extended.
REQ-011 SHALL have port rd_valid, output, 1: rd_data qualifier.
REQ-012 SHALL have port irq, output, 1: OR of all pending button events.

Function
REQ-013 SHALL pass every raw input through a two-flop synchronizer before any other use.
REQ-014 SHALL give each synchronized bit a 16-bit debounce counter: cleared whenever sync equals stable; incremented while sync differs from stable.
REQ-015 SHALL update stable to sync, and clear the counter, on the cycle the counter equals DB_COUNT-1 while sync still differs; total raw-to-stable latency = 2 + DB_COUNT cycles.
REQ-016 SHALL discard any pulse or glitch shorter than DB_COUNT synchronized cycles, leaving stable unchanged.
REQ-017 SHALL, with DB_COUNT = 1, update stable one cycle after sync changes.
REQ-018 SHALL set evt[i] on a 0->1 transition of stable button i; release transitions set nothing.
REQ-019 SHALL keep evt[i] set until cleared by a read of address 2.
REQ-020 SHALL decode rd_addr: 0 = stable switches, 1 = stable buttons, 2 = evt (read-to-clear), 3 = {N_BTN'b0 in upper bits, irq in bit 0}.
REQ-021 SHALL register the read: rd_data and rd_valid are valid exactly one cycle after the rd_en cycle; rd_valid is high for exactly one cycle per rd_en cycle.
REQ-022 SHALL support back-to-back reads on consecutive cycles with no bubbles.
REQ-023 SHALL, on an address-2 read, clear only the evt bits returned in that read.
REQ-024 SHALL let set win when a new press edge and a clear hit the same evt bit in the same cycle; the bit stays 1.
REQ-025 SHALL drive zero on rd_data bits above the selected register width and hold rd_data at its last value when rd_valid is 0.
REQ-026 SHALL drive irq combinationally from the evt register, with no dependence on rd_en.

Reset
REQ-027 SHALL, while reset is low, force to 0: synchronizers, counters, stable, evt, rd_data, rd_valid and irq.
REQ-028 SHALL treat a button held through reset release as a real press: evt sets 2 + DB_COUNT cycles after release.
REQ-029 SHALL abort any in-flight read on reset assertion mid-operation; no rd_valid is produced for it.

Structure
REQ-030 SHALL put address constants (ADDR_SW, ADDR_BTN, ADDR_EVT, ADDR_STAT) and the 16-bit data width in shared package gpio_io_pkg.
REQ-031 SHALL implement per-bit synchronization and debounce in one sub-module, debouncer, instantiated N_SW + N_BTN times via generate.

Verification (DB_COUNT = 4)
REQ-032 SHALL verify: sw_raw 0x00 -> 0xA5 held, then read address 0 -> rd_data = 0x00A5, first visible 6 cycles after the change.
REQ-033 SHALL verify: btn_raw[1] 3-cycle pulse -> stable and evt unchanged, irq stays 0.
REQ-034 SHALL verify: btn_raw[2] pressed for 10 cycles -> irq = 1; read address 2 -> rd_data = 0x0004 and irq = 0 the next cycle.
REQ-035 SHALL verify: new btn[0] edge in the same cycle as an address-2 read -> evt[0] remains 1 and a second read returns 0x0001.
REQ-036 SHALL verify: reads of addresses 0,1,2,3 on 4 consecutive cycles -> 4 consecutive rd_valid pulses with matching data.
REQ-037 SHALL verify: reset asserted mid-debounce and mid-read -> all outputs 0 immediately, with no spurious rd_valid after release.

Source files
------------

// File: rtl/gpio_io_pkg.sv
// rtl/gpio_io_pkg.sv - shared constants for the GPIO input port
package gpio_io_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;

    localparam logic [1:0] ADDR_SW   = 2'd0;
    localparam logic [1:0] ADDR_BTN  = 2'd1;
    localparam logic [1:0] ADDR_EVT  = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/debouncer.sv
// rtl/debouncer.sv - two-flop synchronizer plus counter debounce for one bit
module debouncer
    import gpio_io_pkg::*;
#(
    parameter int unsigned DB_COUNT = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Bring the asynchronous level into the clock domain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

    // Accept the new level only after it has differed for DB_COUNT cycles in a row.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        rise_o   = 1'b0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
                rise_o   = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/gpio_input_port.sv
// rtl/gpio_input_port.sv - debounced switch/button port with read-to-clear events
module gpio_input_port
    import gpio_io_pkg::*;
#(
    parameter int          N_SW     = 8,
    parameter int          N_BTN    = 4,
    parameter int unsigned DB_COUNT = 50000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_SW-1:0]   sw_raw,
    input  logic [N_BTN-1:0]  btn_raw,
    input  logic              rd_en,
    input  logic [1:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              irq
);

    logic [N_SW-1:0]  sw_stable;
    logic [N_SW-1:0]  sw_rise;
    logic [N_BTN-1:0] btn_stable;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] evt_q;
    logic [N_BTN-1:0] evt_d;
    logic [N_BTN-1:0] evt_clr;
    data_t            rd_mux;
    data_t            rd_data_q;
    logic             rd_valid_q;
    logic             unused_sw_rise;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debouncer #(.DB_COUNT(DB_COUNT)) u_db (
            .clock    (clock),
            .reset    (reset),
            .raw_i    (sw_raw[i]),
            .stable_o (sw_stable[i]),
            .rise_o   (sw_rise[i])
        );
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debouncer #(.DB_COUNT(DB_COUNT)) u_db (
            .clock    (clock),
            .reset    (reset),
            .raw_i    (btn_raw[i]),
            .stable_o (btn_stable[i]),
            .rise_o   (btn_rise[i])
        );
    end

    // Switch edges carry no meaning; only their levels are reported.
    assign unused_sw_rise = ^sw_rise;

    assign irq = |evt_q;

    // Clear exactly the bits being returned; a press landing in the same cycle wins.
    always_comb begin
        evt_clr = '0;
        if (rd_en && (rd_addr == ADDR_EVT)) begin
            evt_clr = evt_q;
        end
        evt_d = (evt_q & ~evt_clr) | btn_rise;
    end

    // Register select, zero-extended to the bus width.
    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            ADDR_SW:   rd_mux[N_SW-1:0]  = sw_stable;
            ADDR_BTN:  rd_mux[N_BTN-1:0] = btn_stable;
            ADDR_EVT:  rd_mux[N_BTN-1:0] = evt_q;
            ADDR_STAT: rd_mux[0]         = irq;
            default:   rd_mux            = '0;
        endcase
    end

    // Event latch and registered read port; data holds between reads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            evt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            evt_q      <= evt_d;
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= rd_mux;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_gpio_input_port.sv
// tb/tb_gpio_input_port.sv - scoreboard bench for gpio_input_port
module tb_gpio_input_port;

    localparam int NSW = 8;
    localparam int NBT = 4;
    localparam int DB  = 4;
    localparam int NB  = NSW + NBT;

    logic            clock = 1'b0;
    logic            reset;
    logic [NSW-1:0]  sw_raw;
    logic [NBT-1:0]  btn_raw;
    logic            rd_en;
    logic [1:0]      rd_addr;
    logic [15:0]     rd_data;
    logic            rd_valid;
    logic            irq;

    gpio_input_port #(.N_SW(NSW), .N_BTN(NBT), .DB_COUNT(DB)) dut (
        .clock    (clock),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .btn_raw  (btn_raw),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: raw sample history, debounced levels, pending events.
    logic [NB-1:0]  hist[$];
    logic [NSW-1:0] m_sw;
    logic [NBT-1:0] m_btn;
    logic [NBT-1:0] m_evt;
    logic [15:0]    exp_q[$];
    logic [NB-1:0]  m_cur, m_nxt, m_tmp;
    logic [NBT-1:0] m_rise, m_clr;
    logic [15:0]    m_rv;
    bit             m_flip;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist = {};
            for (int i = 0; i < DB + 2; i++) hist.push_front('0);
            m_sw  = '0;
            m_btn = '0;
            m_evt = '0;
            exp_q = {};
        end else begin
            m_clr = '0;
            if (rd_en) begin
                case (rd_addr)
                    2'd0:    m_rv = {8'h00, m_sw};
                    2'd1:    m_rv = {12'h000, m_btn};
                    2'd2:    begin m_rv = {12'h000, m_evt}; m_clr = m_evt; end
                    default: m_rv = {15'h0000, |m_evt};
                endcase
                exp_q.push_back(m_rv);
            end
            hist.push_front({btn_raw, sw_raw});
            void'(hist.pop_back());
            m_cur = {m_btn, m_sw};
            m_nxt = m_cur;
            // A bit changes once its synchronized samples (age 2..DB+1) all disagree with it.
            for (int b = 0; b < NB; b++) begin
                m_flip = 1'b1;
                for (int a = 2; a <= DB + 1; a++) begin
                    m_tmp = hist[a];
                    if (m_tmp[b] == m_cur[b]) m_flip = 1'b0;
                end
                if (m_flip) m_nxt[b] = ~m_cur[b];
            end
            m_rise = m_nxt[NB-1:NSW] & ~m_cur[NB-1:NSW];
            m_evt  = (m_evt & ~m_clr) | m_rise;
            m_sw   = m_nxt[NSW-1:0];
            m_btn  = m_nxt[NB-1:NSW];
        end
    end

    // Monitor: every read must appear exactly one cycle later with the modelled data.
    logic [15:0] last_exp;
    logic [15:0] obs[$];
    logic [15:0] e;

    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            last_exp = '0;
        end else begin
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rd_valid", 32'(rd_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(e));
                    last_exp = e;
                end
                obs.push_back(rd_data);
            end else begin
                if (exp_q.size() != 0) begin
                    check("missing_rd_valid", 32'(rd_valid), 32'd1);
                    void'(exp_q.pop_front());
                end
                check("rd_data_hold", 32'(rd_data), 32'(last_exp));
            end
            check("irq", 32'(irq), 32'(|m_evt));
        end
    end

    task automatic do_read(input logic [1:0] a, input string nm, input logic [15:0] exp);
        int n0;
        n0 = obs.size();
        @(negedge clock);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge clock);
        rd_en = 1'b0;
        #1;
        if (obs.size() != n0 + 1) check({nm, "_valid"}, 32'(obs.size() - n0), 32'd1);
        else check(nm, 32'(obs[obs.size()-1]), 32'(exp));
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n0;

    initial begin
        sw_raw  = '0;
        btn_raw = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        reset   = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        wait_cyc(3);
        reset = 1'b1;

        // Switch change latency, reading address 0 every cycle.
        @(negedge clock);
        sw_raw  = 8'hA5;
        n0      = obs.size();
        rd_en   = 1'b1;
        rd_addr = 2'd0;
        wait_cyc(8);
        rd_en = 1'b0;
        @(negedge clock);
        #1;
        check("sw_read_count", 32'(obs.size() - n0), 32'd8);
        if (obs.size() >= n0 + 8) begin
            check("sw_before_stable", 32'(obs[n0+5]), 32'h0000);
            check("sw_first_visible", 32'(obs[n0+6]), 32'h00A5);
        end
        do_read(2'd0, "sw_held", 16'h00A5);

        // Short button glitch is ignored.
        @(negedge clock);
        btn_raw[1] = 1'b1;
        wait_cyc(3);
        btn_raw[1] = 1'b0;
        wait_cyc(10);
        #1;
        check("glitch_irq", 32'(irq), 32'd0);
        do_read(2'd1, "glitch_btn", 16'h0000);
        do_read(2'd2, "glitch_evt", 16'h0000);

        // Real press raises irq; read-to-clear drops it.
        @(negedge clock);
        btn_raw[2] = 1'b1;
        wait_cyc(10);
        btn_raw[2] = 1'b0;
        wait_cyc(10);
        #1;
        check("press_irq", 32'(irq), 32'd1);
        do_read(2'd2, "press_evt", 16'h0004);
        check("press_irq_cleared", 32'(irq), 32'd0);

        // Press edge coinciding with a clearing read keeps the bit set.
        @(negedge clock);
        btn_raw[0] = 1'b1;
        wait_cyc(10);
        btn_raw[0] = 1'b0;
        wait_cyc(10);
        btn_raw[0] = 1'b1;
        wait_cyc(5);
        n0      = obs.size();
        rd_en   = 1'b1;
        rd_addr = 2'd2;
        @(negedge clock);
        rd_en = 1'b0;
        #1;
        if (obs.size() == n0 + 1) check("collide_first_read", 32'(obs[n0]), 32'h0001);
        else check("collide_first_valid", 32'(obs.size() - n0), 32'd1);
        check("collide_irq_kept", 32'(irq), 32'd1);
        do_read(2'd2, "collide_second_read", 16'h0001);
        check("collide_irq_after", 32'(irq), 32'd0);
        @(negedge clock);
        btn_raw[0] = 1'b0;
        wait_cyc(10);

        // Back-to-back reads of all four addresses.
        sw_raw     = 8'h3C;
        btn_raw[3] = 1'b1;
        wait_cyc(12);
        n0 = obs.size();
        for (int a = 0; a < 4; a++) begin
            rd_en   = 1'b1;
            rd_addr = 2'(a);
            @(negedge clock);
        end
        rd_en = 1'b0;
        @(negedge clock);
        #1;
        check("b2b_count", 32'(obs.size() - n0), 32'd4);
        if (obs.size() >= n0 + 4) begin
            check("b2b_sw", 32'(obs[n0]), 32'h003C);
            check("b2b_btn", 32'(obs[n0+1]), 32'h0008);
            check("b2b_evt", 32'(obs[n0+2]), 32'h0008);
            check("b2b_stat", 32'(obs[n0+3]), 32'h0000);
        end
        btn_raw[3] = 1'b0;
        wait_cyc(10);

        // Random levels, glitches and reads against the model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            if ($urandom_range(7) == 0) sw_raw[$urandom_range(NSW-1)] ^= 1'b1;
            if ($urandom_range(5) == 0) btn_raw[$urandom_range(NBT-1)] ^= 1'b1;
            rd_en   = ($urandom_range(2) == 0);
            rd_addr = 2'($urandom_range(3));
        end
        @(negedge clock);
        rd_en = 1'b0;
        wait_cyc(12);

        // Reset in the middle of a debounce and a read.
        btn_raw = 4'h1;
        sw_raw  = 8'h0F;
        wait_cyc(3);
        rd_en   = 1'b1;
        rd_addr = 2'd0;
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("mid_reset_rd_valid", 32'(rd_valid), 32'd0);
        check("mid_reset_rd_data", 32'(rd_data), 32'd0);
        check("mid_reset_irq", 32'(irq), 32'd0);
        rd_en = 1'b0;
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(5);
        #1;
        check("held_btn_irq_early", 32'(irq), 32'd0);
        @(negedge clock);
        #1;
        check("held_btn_irq_set", 32'(irq), 32'd1);
        do_read(2'd1, "post_reset_btn", 16'h0001);
        do_read(2'd0, "post_reset_sw", 16'h000F);
        wait_cyc(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
